clk_div_bank: RTL and testbench

Multi-channel programmable clock divider that generates NUM_CH divided clock levels and matching end-of-period strobes from the 2 MHz system clock. Each channel's integer divide ratio is set through a simple valid/ready write port and applied glitch-free at the channel's next period boundary. A global sync pulse phase-aligns all enabled channels. The block serves CPLD timing consumers that need 1 kHz / 8 kHz / ~32 kHz rates, plus any new ratio, without fixed power-of-two taps.

---
 rtl/clk_div_bank_pkg.sv | 15 +
 rtl/clk_div_bank_if.sv | 21 ++
 rtl/clk_div_bank_ch.sv | 95 +++++++++
 rtl/clk_div_bank.sv | 71 +++++++
 tb/tb_clk_div_bank.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_bank_pkg.sv
// Shared constants and types for the clk_div_bank programmable divider bank.
// Default ratios assume a 2 MHz system clock.
package clk_div_bank_pkg;

    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned DIV_1K  = 2000;
    localparam int unsigned DIV_8K  = 250;
    localparam int unsigned DIV_32K = 64;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/clk_div_bank_if.sv
// Ratio write port: valid/ready request with a one-cycle error pulse back.
interface clk_div_bank_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 12
);
    logic             i_cfg_valid;
    logic [CH_W-1:0]  i_cfg_ch;
    logic [CNT_W-1:0] i_cfg_div;
    logic             o_cfg_ready;
    logic             o_cfg_err;

    modport master (
        output i_cfg_valid, i_cfg_ch, i_cfg_div,
        input  o_cfg_ready, o_cfg_err
    );

    modport slave (
        input  i_cfg_valid, i_cfg_ch, i_cfg_div,
        output o_cfg_ready, o_cfg_err
    );
endinterface

// File: rtl/clk_div_bank_ch.sv
// One divider channel: counter, active/pending ratio and registered clk/tick outputs.
// Outputs are computed from next-state so they always agree with the counter.
module clk_div_ch
    import clk_div_bank_pkg::*;
#(
    parameter int unsigned      CNT_W   = 12,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_32K)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wdiv,
    output logic             o_pend,
    output logic             o_clk,
    output logic             o_tick
);
    ch_state_e        r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [CNT_W-1:0] r_div_act, w_div_act_n;
    logic [CNT_W-1:0] r_div_pend, w_div_pend_n;
    logic             r_pend, w_pend_n;
    logic             r_clk, r_tick;
    logic             w_wrap;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_last;

    assign w_wrap = (r_cnt == r_div_act - CNT_W'(1));

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_div_act_n  = r_div_act;
        w_div_pend_n = r_div_pend;
        w_pend_n     = r_pend;
        if (!i_en) begin
            w_state_n = CH_IDLE;
            w_cnt_n   = '0;
            if (i_wr)
                w_div_act_n = i_wdiv;
        end else if (r_state == CH_IDLE || i_sync) begin
            // Start or resync: a same-cycle write wins over an older pending ratio.
            w_state_n = CH_RUN;
            w_cnt_n   = '0;
            w_pend_n  = 1'b0;
            if (i_wr)
                w_div_act_n = i_wdiv;
            else if (r_pend)
                w_div_act_n = r_div_pend;
        end else begin
            if (w_wrap) begin
                w_cnt_n = '0;
                if (r_pend) begin
                    w_div_act_n = r_div_pend;
                    w_pend_n    = 1'b0;
                end
            end else begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
            if (i_wr) begin
                w_div_pend_n = i_wdiv;
                w_pend_n     = 1'b1;
            end
        end
    end

    // ceil(div/2) without needing an extra counter bit
    assign w_half = (w_div_act_n >> 1) + {{(CNT_W-1){1'b0}}, w_div_act_n[0]};
    assign w_last = w_div_act_n - CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= CH_IDLE;
            r_cnt      <= '0;
            r_div_act  <= DEF_DIV;
            r_div_pend <= '0;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_div_act  <= w_div_act_n;
            r_div_pend <= w_div_pend_n;
            r_pend     <= w_pend_n;
            r_clk      <= i_en & (w_cnt_n >= w_half);
            r_tick     <= i_en & (w_cnt_n == w_last);
        end
    end

    assign o_pend = r_pend;
    assign o_clk  = r_clk;
    assign o_tick = r_tick;
endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers sharing one ratio write port
// and a global phase-align sync pulse.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int unsigned               NUM_CH  = 3,
    parameter int unsigned               CNT_W   = 12,
    parameter logic [NUM_CH*CNT_W-1:0]   DEF_DIV = {CNT_W'(DIV_1K), CNT_W'(DIV_8K), CNT_W'(DIV_32K)}
) (
    input  logic              i_InitialSoc,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_sync,
    clk_div_bank_if.slave     cfg,
    output logic [NUM_CH-1:0] o_clk,
    output logic [NUM_CH-1:0] o_tick
);
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_wr;
    logic              w_ready;
    logic              w_ch_ok;
    logic              w_div_ok;
    logic              w_acc;
    logic              r_err;

    // Out-of-range channels report ready so the bad write is accepted and flagged.
    always_comb begin
        w_ready = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++)
            if (32'(cfg.i_cfg_ch) == k)
                w_ready = ~w_pend[k];
    end

    assign w_ch_ok  = (32'(cfg.i_cfg_ch) < NUM_CH);
    assign w_div_ok = (cfg.i_cfg_div >= CNT_W'(MIN_DIV));
    assign w_acc    = cfg.i_cfg_valid & w_ready;

    always_comb begin
        w_wr = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            if (32'(cfg.i_cfg_ch) == k)
                w_wr[k] = w_acc & w_ch_ok & w_div_ok;
    end

    always_ff @(posedge i_InitialSoc or negedge i_rst_n) begin
        if (!i_rst_n)
            r_err <= 1'b0;
        else
            r_err <= w_acc & ~(w_ch_ok & w_div_ok);
    end

    assign cfg.o_cfg_ready = w_ready;
    assign cfg.o_cfg_err   = r_err;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV[k*CNT_W +: CNT_W])
        ) u_ch (
            .i_clk   (i_InitialSoc),
            .i_rst_n (i_rst_n),
            .i_en    (i_en[k]),
            .i_sync  (i_sync),
            .i_wr    (w_wr[k]),
            .i_wdiv  (cfg.i_cfg_div),
            .o_pend  (w_pend[k]),
            .o_clk   (o_clk[k]),
            .o_tick  (o_tick[k])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: period-level reference model compared every cycle,
// plus directed period/duty measurements with hand-computed expectations.
module tb_clk_div_bank;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned CH_W   = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              sync  = 1'b0;
    logic [NUM_CH-1:0] en    = '0;
    logic [NUM_CH-1:0] o_clk;
    logic [NUM_CH-1:0] o_tick;

    clk_div_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

    clk_div_bank #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV ({12'd2000, 12'd250, 12'd64})
    ) dut (
        .i_InitialSoc (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_sync       (sync),
        .cfg          (cfg),
        .o_clk        (o_clk),
        .o_tick       (o_tick)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // Model: each running channel remembers the cycle its period began and its ratio.
    int unsigned defs [NUM_CH] = '{64, 250, 2000};
    int unsigned m_n;
    bit          m_run  [NUM_CH];
    int unsigned m_t0   [NUM_CH];
    int unsigned m_div  [NUM_CH];
    bit          m_pend [NUM_CH];
    int unsigned m_pdiv [NUM_CH];
    bit          m_err;

    function automatic bit m_ready(input int unsigned ch);
        return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
    endfunction

    function automatic bit exp_clk(input int unsigned k);
        if (!m_run[k]) return 1'b0;
        return (m_n - m_t0[k]) >= (m_div[k] + 1) / 2;
    endfunction

    function automatic bit exp_tick(input int unsigned k);
        if (!m_run[k]) return 1'b0;
        return (m_n - m_t0[k]) == m_div[k] - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit          acc, good, w;
        int unsigned wch, wdiv;
        if (!rst_n) begin
            m_n   = 0;
            m_err = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_run[k]  = 0;
                m_t0[k]   = 0;
                m_div[k]  = defs[k];
                m_pend[k] = 0;
                m_pdiv[k] = 0;
            end
        end else begin
            wch   = cfg.i_cfg_ch;
            wdiv  = cfg.i_cfg_div;
            acc   = cfg.i_cfg_valid && m_ready(wch);
            good  = acc && wch < NUM_CH && wdiv >= 2;
            m_err = acc && !good;
            m_n++;
            for (int k = 0; k < NUM_CH; k++) begin
                w = good && wch == k;
                if (!en[k]) begin
                    m_run[k] = 0;
                    if (w) m_div[k] = wdiv;
                end else if (!m_run[k] || sync) begin
                    m_run[k] = 1;
                    m_t0[k]  = m_n;
                    if (w) m_div[k] = wdiv;
                    else if (m_pend[k]) m_div[k] = m_pdiv[k];
                    m_pend[k] = 0;
                end else begin
                    if (m_n - m_t0[k] == m_div[k]) begin
                        m_t0[k] = m_n;
                        if (m_pend[k]) begin
                            m_div[k]  = m_pdiv[k];
                            m_pend[k] = 0;
                        end
                    end
                    if (w) begin
                        m_pend[k] = 1;
                        m_pdiv[k] = wdiv;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_CH-1:0] ec, et;
        for (int k = 0; k < NUM_CH; k++) begin
            ec[k] = exp_clk(k);
            et[k] = exp_tick(k);
        end
        check("model o_clk", int'(o_clk), int'(ec));
        check("model o_tick", int'(o_tick), int'(et));
        check("model o_cfg_ready", int'(cfg.o_cfg_ready), int'(m_ready(cfg.i_cfg_ch)));
        check("model o_cfg_err", int'(cfg.o_cfg_err), int'(m_err));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int dv, input string tag);
        int guard;
        cfg.i_cfg_valid = 1'b1;
        cfg.i_cfg_ch    = CH_W'(ch);
        cfg.i_cfg_div   = CNT_W'(dv);
        #1;
        for (guard = 0; guard < 300 && !cfg.o_cfg_ready; guard++) step(1);
        if (!cfg.o_cfg_ready) begin
            cfg.i_cfg_valid = 1'b0;
            timeout({tag, " ready"});
            return;
        end
        step(1);
        cfg.i_cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int k, input string tag);
        bit seen = 0;
        for (int g = 0; g < 5000 && !seen; g++) begin
            @(negedge clk);
            seen = o_tick[k];
        end
        if (!seen) timeout({tag, " tick"});
    endtask

    task automatic wait_high(input int k, input string tag);
        bit seen = 0;
        for (int g = 0; g < 5000 && !seen; g++) begin
            @(negedge clk);
            seen = o_clk[k];
        end
        if (!seen) timeout({tag, " clk high"});
    endtask

    // Measures the full period following the next tick; low count pins duty.
    task automatic measure(input int k, input int exp_per, input int exp_lo, input string tag);
        int lo = 0, hi = 0;
        bit seen = 0;
        wait_tick(k, tag);
        for (int g = 0; g < 5000 && !seen; g++) begin
            @(negedge clk);
            if (o_clk[k]) hi++; else lo++;
            seen = o_tick[k];
        end
        check({tag, " period"}, lo + hi, exp_per);
        check({tag, " low"}, lo, exp_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg.i_cfg_valid = 1'b0;
        cfg.i_cfg_ch    = '0;
        cfg.i_cfg_div   = '0;
        #2;
        check("reset o_clk", int'(o_clk), 0);
        check("reset o_tick", int'(o_tick), 0);
        check("reset ready", int'(cfg.o_cfg_ready), 1);
        check("reset err", int'(cfg.o_cfg_err), 0);
        step(3);
        rst_n = 1'b1;
        en    = 3'b111;

        measure(0, 64, 32, "ch0 default");
        measure(1, 250, 125, "ch1 default");
        measure(2, 2000, 1000, "ch2 default");

        wait_tick(0, "ch0 align");
        step(3);
        cfg_write(0, 5, "ch0 div5");
        check("ch0 pend ready", int'(cfg.o_cfg_ready), 0);
        cfg.i_cfg_valid = 1'b1;
        cfg.i_cfg_div   = 12'd7;
        step(1);
        check("ch0 second write stalls", int'(cfg.o_cfg_ready), 0);
        cfg.i_cfg_valid = 1'b0;
        measure(0, 5, 3, "ch0 div5");

        step(1);
        cfg_write(1, 1, "div1");
        check("err div1", int'(cfg.o_cfg_err), 1);
        cfg_write(1, 0, "div0");
        check("err div0", int'(cfg.o_cfg_err), 1);
        cfg_write(3, 10, "ch3");
        check("err ch3", int'(cfg.o_cfg_err), 1);
        step(1);
        check("err pulse ends", int'(cfg.o_cfg_err), 0);
        measure(1, 250, 125, "ch1 after rejects");

        step(1);
        sync            = 1'b1;
        cfg.i_cfg_valid = 1'b1;
        cfg.i_cfg_ch    = 2'd1;
        cfg.i_cfg_div   = 12'd10;
        #1;
        check("sync write ready", int'(cfg.o_cfg_ready), 1);
        step(1);
        sync            = 1'b0;
        cfg.i_cfg_valid = 1'b0;
        check("sync o_clk", int'(o_clk), 0);
        check("sync o_tick", int'(o_tick), 0);
        measure(1, 10, 5, "ch1 sync div10");
        measure(0, 5, 3, "ch0 after sync");

        wait_high(2, "ch2 high");
        step(1);
        en = 3'b011;
        step(1);
        check("ch2 off clk", int'(o_clk[2]), 0);
        check("ch2 off tick", int'(o_tick[2]), 0);
        cfg_write(2, 8, "ch2 div8 disabled");
        step(3);
        en = 3'b111;
        measure(2, 8, 4, "ch2 reenable div8");

        step(3);
        cfg_write(0, 6, "ch0 div6");
        en = 3'b110;
        step(4);
        check("ch0 pend kept while off", int'(cfg.o_cfg_ready), 0);
        en = 3'b111;
        measure(0, 6, 3, "ch0 pend on reenable");

        step(2);
        cfg_write(1, 20, "ch1 div20");
        check("ch1 pend before reset", int'(cfg.o_cfg_ready), 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset o_clk", int'(o_clk), 0);
        check("async reset o_tick", int'(o_tick), 0);
        check("async reset ready", int'(cfg.o_cfg_ready), 1);
        check("async reset err", int'(cfg.o_cfg_err), 0);
        step(2);
        rst_n = 1'b1;
        measure(0, 64, 32, "ch0 default after reset");
        measure(1, 250, 125, "ch1 default after reset");

        step(1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
